// File: rtl/mem_wb_skid_latch_if.sv
// Bus between the memory stage, the MEM/WB skid latch and the write-back stage.
// The slave modport is the latch's view; the master modport is the surrounding pipeline's view.
interface mem_wb_skid_latch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] control_wb_in;
  logic [DATA_W-1:0] Read_data_in;
  logic [DATA_W-1:0] ALU_result_in;
  logic [REG_W-1:0]  Write_reg_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] mem_control_wb;
  logic [DATA_W-1:0] Read_data;
  logic [DATA_W-1:0] mem_ALU_result;
  logic [REG_W-1:0]  mem_Write_reg;
  logic [CNT_W-1:0]  wb_count;

  modport slave (
    input  in_valid, control_wb_in, Read_data_in, ALU_result_in, Write_reg_in,
    input  flush, out_ready,
    output in_ready, out_valid, mem_control_wb, Read_data, mem_ALU_result,
    output mem_Write_reg, wb_count
  );

  modport master (
    output in_valid, control_wb_in, Read_data_in, ALU_result_in, Write_reg_in,
    output flush, out_ready,
    input  in_ready, out_valid, mem_control_wb, Read_data, mem_ALU_result,
    input  mem_Write_reg, wb_count
  );
endinterface

// File: rtl/mem_wb_skid_latch.sv
// MEM/WB pipeline latch with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and a counter of retired register writes.
module mem_wb_skid_latch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_wb_skid_latch_if.slave   bus
);

  localparam int unsigned REGWRITE_BIT = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_rdata;
  logic [DATA_W-1:0] main_alu;
  logic [REG_W-1:0]  main_reg;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_rdata;
  logic [DATA_W-1:0] skid_alu;
  logic [REG_W-1:0]  skid_reg;
  logic [CNT_W-1:0]  wb_count;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  // Handshake flags are registered alongside the state so neither ready
  // nor valid has a combinational path from the bus inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      main_ctrl  <= '0;
      main_rdata <= '0;
      main_alu   <= '0;
      main_reg   <= '0;
      skid_ctrl  <= '0;
      skid_rdata <= '0;
      skid_alu   <= '0;
      skid_reg   <= '0;
      wb_count   <= '0;
    end else begin
      if (out_fire && main_ctrl[REGWRITE_BIT]) begin
        wb_count <= wb_count + CNT_W'(1);
      end

      if (bus.flush) begin
        // Bubble: control cleared, data fields left as they were.
        state     <= EMPTY;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_ctrl  <= bus.control_wb_in;
              main_rdata <= bus.Read_data_in;
              main_alu   <= bus.ALU_result_in;
              main_reg   <= bus.Write_reg_in;
              state      <= ONE;
              out_valid  <= 1'b1;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_ctrl  <= bus.control_wb_in;
              main_rdata <= bus.Read_data_in;
              main_alu   <= bus.ALU_result_in;
              main_reg   <= bus.Write_reg_in;
            end else if (in_fire) begin
              skid_ctrl  <= bus.control_wb_in;
              skid_rdata <= bus.Read_data_in;
              skid_alu   <= bus.ALU_result_in;
              skid_reg   <= bus.Write_reg_in;
              state      <= FULL;
              in_ready   <= 1'b0;
            end else if (out_fire) begin
              state      <= EMPTY;
              out_valid  <= 1'b0;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_ctrl  <= skid_ctrl;
              main_rdata <= skid_rdata;
              main_alu   <= skid_alu;
              main_reg   <= skid_reg;
              state      <= ONE;
              in_ready   <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.mem_control_wb = main_ctrl;
  assign bus.Read_data      = main_rdata;
  assign bus.mem_ALU_result = main_alu;
  assign bus.mem_Write_reg  = main_reg;
  assign bus.wb_count       = wb_count;

endmodule

// File: doc/mem_wb_skid_latch.md
# mem_wb_skid_latch

Parametrised successor to the MEM/WB pipeline latch of the five-stage MIPS core. Registers the memory-stage results (write-back control, load data, ALU result, destination register) toward the write-back stage, adding a valid/ready handshake, a 2-entry skid buffer for full-rate stalls, a pipeline flush, and a retired-write counter. It sits between the data-memory stage and the register-file write port.

## Interface
Parameters:
- DATA_W, 32, width of Read_data and ALU result
- REG_W, 5, width of destination register index
- CTRL_W, 2, write-back control width; bit 1 = RegWrite, bit 0 = MemtoReg; CTRL_W >= 2
- CNT_W, 16, width of retired-write counter

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  memory stage presents a valid entry
- in_ready  output  1  latch can accept an entry this cycle
- control_wb_in  input  CTRL_W  write-back control from memory stage
- Read_data_in  input  DATA_W  data-memory read data
- ALU_result_in  input  DATA_W  ALU result
- Write_reg_in  input  REG_W  destination register index
- flush  input  1  discard all held entries
- out_valid  output  1  write-back entry valid
- out_ready  input  1  write-back stage consumes entry
- mem_control_wb  output  CTRL_W  registered control
- Read_data  output  DATA_W  registered load data
- mem_ALU_result  output  DATA_W  registered ALU result
- mem_Write_reg  output  REG_W  registered destination
- wb_count  output  CNT_W  count of consumed entries with RegWrite=1

## Operation
- Storage: main register (drives outputs) plus one skid register; state EMPTY / ONE / FULL.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- EMPTY: in_fire -> load main, go ONE.
- ONE: in_fire & out_fire -> load main with input, stay ONE; in_fire & !out_fire -> load skid, go FULL; out_fire only -> EMPTY.
- FULL: in_ready=0; out_fire -> main <= skid, go ONE; else hold.
- in_ready = (state != FULL), purely registered; no combinational path from out_ready or in_valid.
- out_valid = (state != EMPTY).
- flush (highest priority below rst): state -> EMPTY, mem_control_wb and skid control forced to 0 (bubble); data/reg fields hold. Input offered in the flush cycle is accepted (in_ready as normal) and discarded. An out_fire in the flush cycle still counts.
- wb_count increments by 1 on each out_fire where mem_control_wb[1]=1; wraps from 2^CNT_W-1 to 0.
- Outputs stable while out_valid & !out_ready.

## Timing
- Reset (rst=1 at edge): state EMPTY, in_ready=1, out_valid=0, mem_control_wb=0, Read_data=0, mem_ALU_result=0, mem_Write_reg=0, wb_count=0, skid contents 0. rst overrides flush and all handshakes.
- Latency: entry accepted at edge N appears on outputs with out_valid=1 after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Stall: with out_ready=0, accepts at most 2 entries, then in_ready=0 the cycle after the second accept.
- Release from FULL: first out_fire moves skid to main; in_ready rises the following cycle.
- Ordering strictly FIFO; no entry dropped or duplicated except by flush.

## Test plan
- Reset: drive rst=1 one cycle with all inputs nonzero -> all outputs 0, in_ready=1, out_valid=0, wb_count=0.
- Pass-through: out_ready=1, present {ctrl=2'b10, Read_data_in=2, ALU=3, reg=4} -> next cycle out_valid=1, outputs 2'b10/2/3/4; wb_count=1 after consumption.
- Stall/skid: out_ready=0, offer entries A(ALU=10), B(ALU=11), C(ALU=12) back-to-back -> A, B accepted, in_ready=0, C held; raise out_ready -> outputs A, B, C in order on consecutive cycles.
- Flush: in FULL state assert flush with new in_valid -> next cycle out_valid=0, mem_control_wb=0, in_ready=1; offered entry never appears.
- Counter wrap: CNT_W=4, consume 17 entries with ctrl=2'b10 and 3 with ctrl=2'b01 -> wb_count=1.
- Reset mid-operation: rst in FULL state with out_ready=1 -> next cycle EMPTY, all outputs 0, wb_count=0, no entry emitted.
